// File: rtl/snn_pkg.sv
// Shared definitions for the spiking core's edge blocks: default sizes,
// index-width helper and the output decoder state encoding.
package snn_pkg;

  localparam int unsigned N_NEURON_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_HOLD  = 2'd3
  } dec_state_e;

  // Ceiling log2, never less than 1 so single-entry indices still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Per-neuron spike counter: synchronous clear, increment enable, saturates
// at all-ones instead of wrapping.
module spike_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_decoder.sv
// Rate-coded readout: integrates output spikes over WINDOW timesteps, then
// scans the per-neuron counts for the argmax and presents it via valid/ready.
module spike_decoder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURON = N_NEURON_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned WINDOW   = 16,
  parameter int unsigned IDX_W    = clog2_min1(N_NEURON)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [N_NEURON-1:0] spike_in,
  input  logic                ready,
  output logic                busy,
  output logic                valid,
  output logic [IDX_W-1:0]    class_out,
  output logic [CNT_W-1:0]    count_out,
  output logic                tie
);

  localparam int unsigned WIN_W = clog2_min1(WINDOW);

  dec_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] class_q, class_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             tie_q, tie_d;

  logic             cnt_clr;
  logic             accum_en;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W-1:0] cnt_w [N_NEURON];

  for (genvar g = 0; g < N_NEURON; g++) begin : g_cnt
    spike_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .clr_i  (cnt_clr),
      .inc_i  (accum_en & spike_in[g]),
      .cnt_o  (cnt_w[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    idx_d    = idx_q;
    class_d  = class_q;
    max_d    = max_q;
    tie_d    = tie_q;
    cnt_clr  = 1'b0;
    accum_en = 1'b0;
    sel_cnt  = cnt_w[idx_q];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          win_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accum_en = 1'b1;
        if (win_q == WIN_W'(WINDOW - 1)) begin
          idx_d   = '0;
          state_d = ST_SCAN;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      ST_SCAN: begin
        // Strict-greater replacement keeps the lowest index on ties.
        if (idx_q == '0) begin
          max_d   = sel_cnt;
          class_d = '0;
          tie_d   = 1'b0;
        end else if (sel_cnt > max_q) begin
          max_d   = sel_cnt;
          class_d = idx_q;
          tie_d   = 1'b0;
        end else if (sel_cnt == max_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == IDX_W'(N_NEURON - 1)) begin
          state_d = ST_HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      class_q <= '0;
      max_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
    end
  end

  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_SCAN);
  assign valid     = (state_q == ST_HOLD);
  assign class_out = class_q;
  assign count_out = max_q;
  assign tie       = tie_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder: default instance plus a CNT_W=3 instance
// driven with identical stimulus, each checked against its own scoreboard.
module tb_spike_decoder;
  import snn_pkg::*;

  localparam int unsigned NN  = 8;
  localparam int unsigned WIN = 16;

  typedef struct packed {
    logic [2:0] cls;
    logic [7:0] cnt;
    logic       tie;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, start, ready;
  logic [7:0] spike_in;

  logic       busy_a, valid_a, tie_a;
  logic [2:0] class_a;
  logic [7:0] count_a;
  logic       busy_b, valid_b, tie_b;
  logic [2:0] class_b;
  logic [2:0] count_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] pat [WIN];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  spike_decoder u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .spike_in(spike_in), .ready(ready),
    .busy(busy_a), .valid(valid_a), .class_out(class_a), .count_out(count_a), .tie(tie_a)
  );

  spike_decoder #(
    .CNT_W(3)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .spike_in(spike_in), .ready(ready),
    .busy(busy_b), .valid(valid_b), .class_out(class_b), .count_out(count_b), .tie(tie_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned w);
    int unsigned c [NN];
    int unsigned lim, mx;
    exp_t        e;
    lim = (1 << w) - 1;
    for (int i = 0; i < NN; i++) c[i] = 0;
    for (int t = 0; t < WIN; t++)
      for (int i = 0; i < NN; i++)
        if (pat[t][i] && c[i] < lim) c[i]++;
    e.cls = '0;
    e.tie = 1'b0;
    mx    = c[0];
    for (int i = 1; i < NN; i++) begin
      if (c[i] > mx) begin
        mx    = c[i];
        e.cls = 3'(i);
        e.tie = 1'b0;
      end else if (c[i] == mx) begin
        e.tie = 1'b1;
      end
    end
    e.cnt = mx[7:0];
    return e;
  endfunction

  // One full inference; spikes in the start cycle and after the window are 8'hFF
  // and must not be counted. A start pulse mid-window must be ignored.
  task automatic do_inference(input int hold_n, input bit start_in_hold);
    exp_t ea, eb;
    int   n;
    q_a.push_back(model(8));
    q_b.push_back(model(3));
    @(negedge clk); start = 1'b1; spike_in = 8'hFF;
    @(posedge clk);
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_accum", busy_a, 1);
      start    = (k == 7);
      spike_in = pat[k];
      @(posedge clk);
    end
    @(negedge clk); start = 1'b0; spike_in = 8'hFF;
    check("busy_scan", busy_a, 1);
    check("valid_scan", valid_a, 0);
    n = 0;
    while (valid_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    spike_in = 8'h00;
    check("latency", n, NN);
    check("busy_in_hold", busy_a, 0);
    check("valid_b", valid_b, 1);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check("class_a", class_a, ea.cls);
    check("count_a", count_a, ea.cnt);
    check("tie_a", tie_a, ea.tie);
    check("class_b", class_b, eb.cls);
    check("count_b", count_b, eb.cnt);
    check("tie_b", tie_b, eb.tie);
    for (int h = 0; h < hold_n; h++) begin
      start = start_in_hold;
      @(negedge clk);
      check("hold_valid", valid_a, 1);
      check("hold_class", class_a, ea.cls);
      check("hold_count", count_a, ea.cnt);
      check("hold_tie", tie_a, ea.tie);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("valid_after_hs", valid_a, 0);
    check("busy_after_hs", busy_a, 0);
    check("class_kept", class_a, ea.cls);
    check("count_kept", count_a, ea.cnt);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; ready = 1'b0; spike_in = '0;
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_class", class_a, 0);
    check("rst_count", count_a, 0);
    check("rst_tie", tie_a, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < WIN; k++) pat[k] = 8'hFF;
    do_inference(0, 1'b0);

    for (int k = 0; k < WIN; k++) pat[k] = 8'h20 | ((k % 2 == 0) ? 8'h04 : 8'h00);
    do_inference(5, 1'b1);

    for (int k = 0; k < WIN; k++) pat[k] = 8'h80 | ((k < 6) ? 8'h02 : 8'h00);
    do_inference(1, 1'b0);

    for (int k = 0; k < WIN; k++) pat[k] = 8'h88;
    do_inference(0, 1'b0);

    // Abort a window with async reset after eight ACCUM cycles.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); start = 1'b0; spike_in = 8'h80;
      @(posedge clk);
    end
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_valid", valid_a, 0);
    check("abort_class", class_a, 0);
    check("abort_count", count_a, 0);
    check("abort_tie", tie_a, 0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1; spike_in = 8'h00;

    for (int k = 0; k < WIN; k++) pat[k] = 8'h01;
    do_inference(0, 1'b0);

    for (int k = 0; k < WIN; k++) pat[k] = 8'h00;
    do_inference(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spike_decoder.md
Name: spike_decoder

Overview:
Output-side reader for the spiking core's 8-bit output_spike bus. It integrates spikes per output neuron over a fixed window of timesteps, then scans the counts and reports the winning class (rate-coded argmax) through a valid/ready handshake. It sits between the controller's output_spike and the host/readout logic, mirroring the input spike generator on the other side of the core.

Parameters:
N_NEURON, 8, number of output neurons (width of spike_in)
CNT_W, 8, width of each per-neuron spike counter (saturating)
WINDOW, 16, number of timesteps integrated per inference (>=1)
IDX_W, 3, width of class index (= clog2(N_NEURON), minimum 1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a new integration window (sampled only in IDLE)
spike_in  in  N_NEURON  one bit per output neuron, one timestep per clock
ready  in  1  consumer accepts result
busy  out  1  high in ACCUM and SCAN
valid  out  1  result available (HOLD state)
class_out  out  IDX_W  index of neuron with the highest count
count_out  out  CNT_W  spike count of the winning neuron
tie  out  1  another neuron shares the winning count

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters, window counter and scan registers 0; busy=0, valid=0, class_out=0, count_out=0, tie=0. Reset mid-window or mid-scan abandons the result; no partial valid.
- States: IDLE -> ACCUM -> SCAN -> HOLD -> IDLE.
- IDLE: on start=1, clear all counters and window counter; next state ACCUM. start is ignored in every other state.
- ACCUM: exactly WINDOW cycles. Each cycle, counter[i] += spike_in[i]; saturates at 2^CNT_W-1 (no wrap). Window counter counts 0..WINDOW-1; at WINDOW-1 -> SCAN. spike_in in the start cycle and after the last ACCUM cycle is ignored.
- SCAN: N_NEURON cycles, one neuron per cycle in index order 0..N_NEURON-1. Running max initialised from neuron 0. Replace only on strict greater -> lowest index wins ties. tie set when a later neuron equals the current max; cleared when a new strict max is found. After index N_NEURON-1 -> HOLD.
- HOLD: valid=1; class_out, count_out, tie stable and held until valid&&ready. On handshake, the next state is IDLE, valid drops the next cycle, and outputs keep last values (not cleared).
- ready is ignored outside HOLD. No combinational path from ready to valid.
- Latency: start high at cycle 0 -> ACCUM cycles 1..WINDOW -> SCAN cycles WINDOW+1..WINDOW+N_NEURON -> valid=1 from cycle WINDOW+N_NEURON+1 (25 with defaults).
- All-zero counts: class_out=0, count_out=0, tie=1 (tie=0 if N_NEURON=1).
- busy=1 exactly in ACCUM and SCAN; busy and valid are never high together.

Decomposition:
- Shared package snn_pkg holds the N_NEURON default, CNT_W default, the clog2 helper, and the decoder state encoding (IDLE=0, ACCUM=1, SCAN=2, HOLD=3) so the spike generator and the bench share them.
- One natural sub-module is spike_counter, a CNT_W saturating counter with sync clear and increment enable, instantiated N_NEURON times.
- The FSM, window counter and argmax scan stay in spike_decoder.

Test Plan:
- Defaults, start pulse, spike_in=8'hFF for 16 cycles -> valid at cycle 25, class_out=0, count_out=16, tie=1, busy low while valid.
- spike_in bit5 high all 16 cycles, bit2 high on alternate cycles, others 0 -> class_out=5, count_out=16, tie=0; then a ready pulse -> valid falls the next cycle and the FSM is in IDLE.
- CNT_W=3, bit7 high for 16 cycles, bit1 high for 6 cycles -> count_out=7 (saturated), class_out=7, tie=0. In a separate run, bits 3 and 7 both high for 16 cycles -> class_out=3, tie=1.
- Backpressure: hold ready=0 for 5 cycles in HOLD -> valid stays 1 and all outputs stay constant. Pulse start during HOLD and during ACCUM -> no effect on the window length or the result.
- Assert reset_n=0 in ACCUM cycle 8 for 2 cycles -> all outputs 0 immediately (async). The next start with spike_in=8'h01 for 16 cycles -> class_out=0, count_out=16, tie=0, unaffected by the aborted window.
- No spikes for the whole window -> class_out=0, count_out=0, tie=1; spikes applied in the start cycle and the cycle after ACCUM ends are not counted.
